enclave_cmd_queue: RTL



---
 rtl/enclave_cmd_queue.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/enclave_cmd_queue.sv
// Wishbone command FIFO and issue sequencer for the enclave compute core.
// Define ENCLAVE_CMDQ_IRQ_EN to build the completion interrupt.
module enclave_cmd_queue #(
   parameter int          ADDR_WIDTH  = 10,
   parameter int          CMD_DEPTH   = 4,
   parameter logic [31:0] OPCODE_ADDR = 32'h3000_0000,
   parameter logic [31:0] STATUS_ADDR = 32'h3000_0004
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  wbs_stb_i,
   input  logic                  wbs_cyc_i,
   input  logic                  wbs_we_i,
   input  logic [3:0]            wbs_sel_i,
   input  logic [31:0]           wbs_adr_i,
   input  logic [31:0]           wbs_dat_i,
   output logic                  wbs_ack_o,
   output logic [31:0]           wbs_dat_o,
   output logic                  cmd_valid_o,
   input  logic                  cmd_ready_i,
   output logic [1:0]            cmd_op_o,
   output logic [ADDR_WIDTH-1:0] cmd_src1_o,
   output logic [ADDR_WIDTH-1:0] cmd_src2_o,
   output logic [ADDR_WIDTH-1:0] cmd_dst_o,
   input  logic                  core_done_i,
   output logic                  busy_o,
   output logic                  irq_o
);

   localparam int PW = $clog2(CMD_DEPTH);
   localparam logic [PW-1:0] PTR_ONE = 1;
   localparam logic [PW:0]   CNT_ONE = 1;
   localparam logic [PW:0]   CNT_MAX = CMD_DEPTH;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   state_t state, state_n;

   logic [31:0]   mem [CMD_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [PW:0]   count;
   logic          full, empty;
   logic [31:0]   head;

   logic          sel_op, sel_st, req;
   logic          push_req, push_ok, st_wr;
   logic          pop, done_acc, ovf_set;
   logic          overflow;
   logic [7:0]    done_count;
   logic [31:0]   status, rd_data;

   assign full  = (count == CNT_MAX);
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   assign sel_op   = (wbs_adr_i == OPCODE_ADDR);
   assign sel_st   = (wbs_adr_i == STATUS_ADDR);
   assign req      = wbs_stb_i & wbs_cyc_i & (sel_op | sel_st) & ~wbs_ack_o;
   assign push_req = req & wbs_we_i & sel_op & (wbs_sel_i == 4'b1111);
   assign st_wr    = req & wbs_we_i & sel_st;

   // a same-cycle pop frees the slot, so a full FIFO can still accept
   assign push_ok = push_req & (~full | pop);
   assign ovf_set = push_req & full & ~pop;

   assign status = {16'h0, done_count, 4'(count),
                    overflow, busy_o, empty, full};

   // read mux for the two decoded addresses
   always_comb begin
      rd_data = '0;
      unique case (1'b1)
         sel_op:  rd_data = empty ? '0 : head;
         sel_st:  rd_data = status;
         default: rd_data = '0;
      endcase
   end

   // single-cycle ack; read data only travels alongside a read ack
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         wbs_ack_o <= req;
         wbs_dat_o <= (req & ~wbs_we_i) ? rd_data : '0;
      end
   end

   // command storage, no reset needed since count guards every read
   always_ff @(posedge wb_clk_i) begin
      if (push_ok)
         mem[wr_ptr] <= wbs_dat_i;
   end

   // circular pointers and occupancy
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (push_ok & ~pop)
            count <= count + CNT_ONE;
         else if (pop & ~push_ok)
            count <= count - CNT_ONE;
      end
   end

   // issue sequencing: drop NOPs, hand others to the core, await done
   always_comb begin
      state_n  = state;
      pop      = 1'b0;
      done_acc = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               if (head[1:0] == 2'b00)
                  pop = 1'b1;
               else
                  state_n = ISSUE;
            end
         end
         ISSUE: begin
            if (cmd_valid_o & cmd_ready_i) begin
               pop     = 1'b1;
               state_n = WAIT;
            end
         end
         WAIT: begin
            if (core_done_i) begin
               done_acc = 1'b1;
               state_n  = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)
         state <= IDLE;
      else
         state <= state_n;
   end

   // registered handshake and busy flags; valid drops on the accepting edge
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         cmd_valid_o <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         cmd_valid_o <= (state == ISSUE) & ~(cmd_valid_o & cmd_ready_i);
         busy_o      <= (state != IDLE);
      end
   end

   assign cmd_op_o   = cmd_valid_o ? head[1:0] : '0;
   assign cmd_src1_o = cmd_valid_o ? head[2 +: ADDR_WIDTH] : '0;
   assign cmd_src2_o = cmd_valid_o ? head[2+ADDR_WIDTH +: ADDR_WIDTH] : '0;
   assign cmd_dst_o  = cmd_valid_o ? head[2+2*ADDR_WIDTH +: ADDR_WIDTH] : '0;

   // sticky overflow and completion counter, both cleared by a status write
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         overflow   <= 1'b0;
         done_count <= '0;
      end else if (st_wr) begin
         overflow   <= 1'b0;
         done_count <= '0;
      end else begin
         if (ovf_set)
            overflow <= 1'b1;
         if (done_acc)
            done_count <= done_count + 8'd1;
      end
   end

`ifdef ENCLAVE_CMDQ_IRQ_EN
   // one-cycle interrupt following each accepted completion
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)
         irq_o <= 1'b0;
      else
         irq_o <= done_acc;
   end
`else
   assign irq_o = 1'b0;
`endif

endmodule
